// File: rtl/acfa_cfa_pkg.sv
// Shared CFA definitions: loop-count field defaults, expander state encoding and
// event-counter limits, common to the loop monitor and the verifier-side expander.
package acfa_cfa_pkg;

  localparam int ADDR_W   = 16;
  localparam int CTR_SIZE = 32;
  localparam int CTR_MIN  = 1;
  localparam int EVT_W    = 32;

  localparam logic [EVT_W-1:0] EVT_TOTAL_MAX = 32'hFFFF_FFFF;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } exp_state_t;

endpackage

// File: rtl/loop_expander_if.sv
// Record-in / event-out handshake bundle between the CFLog reader, the loop
// expander and the path verifier.
interface loop_expander_if
  import acfa_cfa_pkg::*;
#(
  parameter int CTR_SIZE = acfa_cfa_pkg::CTR_SIZE
) ();

  logic                in_valid;
  logic                in_ready;
  logic [ADDR_W-1:0]   in_src;
  logic [ADDR_W-1:0]   in_dest;
  logic [CTR_SIZE-1:0] in_ctr;

  logic                out_valid;
  logic                out_ready;
  logic [ADDR_W-1:0]   out_src;
  logic [ADDR_W-1:0]   out_dest;
  logic                out_last;

  modport master (
    output in_valid, in_src, in_dest, in_ctr, out_ready,
    input  in_ready, out_valid, out_src, out_dest, out_last
  );

  modport slave (
    input  in_valid, in_src, in_dest, in_ctr, out_ready,
    output in_ready, out_valid, out_src, out_dest, out_last
  );

endinterface

// File: rtl/loop_expander.sv
// Expands (src, dest, count) loop records into count branch events; first event one cycle
// after acceptance, one event/cycle; stalls on out_ready, takes the next record on the final handshake.
module loop_expander
  import acfa_cfa_pkg::*;
#(
  parameter int CTR_SIZE = acfa_cfa_pkg::CTR_SIZE,
  parameter int CTR_MIN  = acfa_cfa_pkg::CTR_MIN
) (
  input  logic             clk,
  input  logic             reset_n,
  loop_expander_if.slave   io,
  output logic             err_zero_ctr,
  output logic [EVT_W-1:0] evt_total
);

  typedef logic [CTR_SIZE:0] rem_t;

  localparam logic [CTR_SIZE-1:0] CTR_MIN_C = CTR_SIZE'(CTR_MIN);
  localparam rem_t                REM_ONE   = rem_t'(1);
  localparam rem_t                REM_TWO   = rem_t'(2);

  exp_state_t        state_q;
  rem_t              rem_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dest_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              err_q;
  logic [EVT_W-1:0]  evt_total_q;

  logic              in_hs;
  logic              out_hs;
  logic              ctr_low;
  logic [CTR_SIZE-1:0] ctr_eff;
  rem_t              rec_events;

  // Extra MSB on rem keeps count - CTR_MIN + 1 from wrapping when CTR_MIN is 0.
  assign ctr_low    = (io.in_ctr < CTR_MIN_C);
  assign ctr_eff    = ctr_low ? CTR_MIN_C : io.in_ctr;
  assign rec_events = {1'b0, ctr_eff} - {1'b0, CTR_MIN_C} + REM_ONE;

  assign io.in_ready = (state_q == IDLE) | (out_last_q & io.out_ready);
  assign in_hs       = io.in_valid & io.in_ready;
  assign out_hs      = out_valid_q & io.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      src_q       <= '0;
      dest_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      evt_total_q <= '0;
    end else begin
      if (out_hs && (evt_total_q != EVT_TOTAL_MAX)) begin
        evt_total_q <= evt_total_q + 1'b1;
      end

      // A new record can only be accepted in IDLE or on the final handshake,
      // so it always takes priority over the decrement path.
      if (in_hs) begin
        state_q     <= EMIT;
        src_q       <= io.in_src;
        dest_q      <= io.in_dest;
        rem_q       <= rec_events;
        out_valid_q <= 1'b1;
        out_last_q  <= (rec_events == REM_ONE);
        if (ctr_low) begin
          err_q <= 1'b1;
        end
      end else if (out_hs) begin
        if (out_last_q) begin
          state_q     <= IDLE;
          rem_q       <= '0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end else begin
          rem_q      <= rem_q - REM_ONE;
          out_last_q <= (rem_q == REM_TWO);
        end
      end
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_src   = src_q;
  assign io.out_dest  = dest_q;
  assign io.out_last  = out_last_q;
  assign err_zero_ctr = err_q;
  assign evt_total    = evt_total_q;

endmodule

// File: tb/tb_loop_expander.sv
// Directed bench for loop_expander: single, multi, back-to-back, stalled, zero-count and mid-loop reset.
module tb_loop_expander;
  import acfa_cfa_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        err_zero_ctr;
  logic [31:0] evt_total;

  int vectors;
  int miscompares;

  loop_expander_if #(.CTR_SIZE(32)) bus ();

  loop_expander #(.CTR_SIZE(32), .CTR_MIN(1)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .io           (bus),
    .err_zero_ctr (err_zero_ctr),
    .evt_total    (evt_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge, then let outputs settle.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] s, input logic [15:0] d, input logic [31:0] c);
    bus.in_valid = 1'b1;
    bus.in_src   = s;
    bus.in_dest  = d;
    bus.in_ctr   = c;
  endtask

  logic [6:0] pat;
  int         sent;

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_src    = '0;
    bus.in_dest   = '0;
    bus.in_ctr    = '0;
    bus.out_ready = 1'b0;
    repeat (3) adv();

    // Reset state
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_src", bus.out_src, 0);
    check("rst_out_dest", bus.out_dest, 0);
    check("rst_err", err_zero_ctr, 0);
    check("rst_evt", evt_total, 0);
    reset_n = 1'b1;
    adv();

    // Single non-looped branch
    bus.out_ready = 1'b1;
    offer(16'hE000, 16'hE010, 32'd1);
    #1 check("t1_in_ready", bus.in_ready, 1);
    adv();
    bus.in_valid = 1'b0;
    #1;
    check("t1_out_valid", bus.out_valid, 1);
    check("t1_out_src", bus.out_src, 16'hE000);
    check("t1_out_dest", bus.out_dest, 16'hE010);
    check("t1_out_last", bus.out_last, 1);
    check("t1_evt_pre", evt_total, 0);
    adv();
    check("t1_idle", bus.out_valid, 0);
    check("t1_evt", evt_total, 1);

    // Count 5: five back-to-back events, last only on the fifth
    offer(16'hE020, 16'hE008, 32'd5);
    adv();
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      check("t2_valid", bus.out_valid, 1);
      check("t2_src", bus.out_src, 16'hE020);
      check("t2_dest", bus.out_dest, 16'hE008);
      check("t2_last", bus.out_last, (i == 5));
      check("t2_in_ready", bus.in_ready, (i == 5));
      adv();
    end
    check("t2_idle", bus.out_valid, 0);
    check("t2_evt", evt_total, 6);

    // Count 3 followed immediately by count 2: no bubble
    offer(16'hE100, 16'hE104, 32'd3);
    adv();
    offer(16'hE200, 16'hE204, 32'd2);
    for (int k = 1; k <= 5; k++) begin
      if (k == 4) bus.in_valid = 1'b0;
      #1;
      check("t3_valid", bus.out_valid, 1);
      check("t3_src", bus.out_src, (k <= 3) ? 16'hE100 : 16'hE200);
      check("t3_dest", bus.out_dest, (k <= 3) ? 16'hE104 : 16'hE204);
      check("t3_last", bus.out_last, (k == 3 || k == 5));
      check("t3_in_ready", bus.in_ready, (k == 3 || k == 5));
      adv();
    end
    check("t3_idle", bus.out_valid, 0);
    check("t3_evt", evt_total, 11);

    // Count 4 under stalls: out_ready 1,0,0,1,0,1,1 -> handshakes on cycles 1,4,6,7
    offer(16'hE300, 16'hE304, 32'd4);
    adv();
    bus.in_valid = 1'b0;
    pat  = 7'b1101001;
    sent = 0;
    for (int c = 0; c < 7; c++) begin
      bus.out_ready = pat[c];
      #1;
      check("t4_valid", bus.out_valid, 1);
      check("t4_src", bus.out_src, 16'hE300);
      check("t4_dest", bus.out_dest, 16'hE304);
      check("t4_last", bus.out_last, (sent == 3));
      check("t4_in_ready", bus.in_ready, (sent == 3) && pat[c]);
      adv();
      if (pat[c]) sent++;
    end
    check("t4_idle", bus.out_valid, 0);
    check("t4_evt", evt_total, 15);

    // Zero count: one event, sticky error flag
    bus.out_ready = 1'b1;
    offer(16'hE400, 16'hE404, 32'd0);
    adv();
    bus.in_valid = 1'b0;
    #1;
    check("t5_err_set", err_zero_ctr, 1);
    check("t5_valid", bus.out_valid, 1);
    check("t5_last", bus.out_last, 1);
    adv();
    check("t5_idle", bus.out_valid, 0);
    check("t5_evt", evt_total, 16);
    offer(16'hE500, 16'hE504, 32'd2);
    adv();
    bus.in_valid = 1'b0;
    repeat (2) adv();
    check("t5_idle2", bus.out_valid, 0);
    check("t5_err_sticky", err_zero_ctr, 1);
    check("t5_evt2", evt_total, 18);

    // Reset during the 2nd of 6 repetitions
    offer(16'hE600, 16'hE604, 32'd6);
    adv();
    bus.in_valid = 1'b0;
    #1 check("t6_rep1", bus.out_valid, 1);
    adv();
    check("t6_rep2_valid", bus.out_valid, 1);
    check("t6_rep2_last", bus.out_last, 0);
    reset_n = 1'b0;
    #1;
    check("t6_async_valid", bus.out_valid, 0);
    check("t6_async_src", bus.out_src, 0);
    check("t6_async_err", err_zero_ctr, 0);
    check("t6_async_evt", evt_total, 0);
    adv();
    reset_n = 1'b1;
    #1;
    check("t6_in_ready", bus.in_ready, 1);
    check("t6_evt", evt_total, 0);
    adv();
    check("t6_idle", bus.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
